// File: rtl/local_endpoint.sv
// Local-port network interface: core TX FIFO feeding the router under credit control,
// and an RX buffer draining router flits to the core with one credit returned per pop.
module local_endpoint #(
    parameter int CREDITS  = 4,
    parameter int TX_DEPTH = 4,
    parameter int XCOORD   = 0,
    parameter int YCOORD   = 0,
    localparam int CW      = $clog2(CREDITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tx_valid_i,
    input  logic [7:0]    tx_dest_i,
    input  logic [7:0]    tx_payload_i,
    output logic          tx_ready_o,
    output logic [15:0]   link_data_o,
    output logic          link_enable_o,
    input  logic          link_credit_i,
    input  logic [15:0]   link_data_i,
    input  logic          link_enable_i,
    output logic          link_credit_o,
    output logic          rx_valid_o,
    output logic [15:0]   rx_data_o,
    input  logic          rx_ready_i,
    output logic [CW-1:0] credit_count_o,
    output logic          misroute_o,
    output logic          err_o
);
    localparam int TPW = $clog2(TX_DEPTH);
    localparam int RPW = (CREDITS > 1) ? $clog2(CREDITS) : 1;
    localparam logic [7:0]     MY_ADDR    = {4'(XCOORD), 4'(YCOORD)};
    localparam logic [CW-1:0]  CREDIT_MAX = CW'(CREDITS);
    localparam logic [RPW-1:0] RX_LAST    = RPW'(CREDITS - 1);

    // ---------------- TX path ----------------
    logic [15:0]   tx_mem [TX_DEPTH];
    logic [TPW:0]  tx_wr_ptr_reg, tx_rd_ptr_reg;
    logic [CW-1:0] credit_reg, credit_next;
    logic          credit_err;
    logic [15:0]   link_data_reg;
    logic          link_enable_reg;
    logic          tx_empty, tx_full, tx_push, tx_send;

    assign tx_empty = (tx_wr_ptr_reg == tx_rd_ptr_reg);
    assign tx_full  = (tx_wr_ptr_reg[TPW] != tx_rd_ptr_reg[TPW]) &&
                      (tx_wr_ptr_reg[TPW-1:0] == tx_rd_ptr_reg[TPW-1:0]);
    assign tx_push  = tx_valid_i && !tx_full;
    assign tx_send  = !tx_empty && (credit_reg != '0);

    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wr_ptr_reg[TPW-1:0]] <= {tx_payload_i, tx_dest_i};
    end

    // A credit returned while already full is a protocol error; the count saturates.
    always_comb begin
        credit_next = credit_reg;
        credit_err  = 1'b0;
        case ({tx_send, link_credit_i})
            2'b10: credit_next = credit_reg - 1'b1;
            2'b01: begin
                if (credit_reg == CREDIT_MAX) credit_err  = 1'b1;
                else                          credit_next = credit_reg + 1'b1;
            end
            default: credit_next = credit_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wr_ptr_reg   <= '0;
            tx_rd_ptr_reg   <= '0;
            credit_reg      <= CREDIT_MAX;
            link_data_reg   <= '0;
            link_enable_reg <= 1'b0;
        end else begin
            if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + 1'b1;
            if (tx_send) begin
                tx_rd_ptr_reg <= tx_rd_ptr_reg + 1'b1;
                link_data_reg <= tx_mem[tx_rd_ptr_reg[TPW-1:0]];
            end
            link_enable_reg <= tx_send;
            credit_reg      <= credit_next;
        end
    end

    // ---------------- RX path ----------------
    logic [15:0]    rx_mem_reg [CREDITS];
    logic [RPW-1:0] rx_wr_ptr_reg, rx_rd_ptr_reg;
    logic [CW-1:0]  rx_count_reg;
    logic           rx_full, rx_pop, rx_write, rx_overflow;
    logic           link_credit_reg, misroute_reg, err_reg;

    assign rx_full     = (rx_count_reg == CREDIT_MAX);
    assign rx_valid_o  = (rx_count_reg != '0);
    assign rx_pop      = rx_valid_o && rx_ready_i;
    // A pop on the same edge frees the slot, so a full buffer can still accept.
    assign rx_write    = link_enable_i && (!rx_full || rx_pop);
    assign rx_overflow = link_enable_i && rx_full && !rx_pop;

    generate
        for (genvar gi = 0; gi < CREDITS; gi++) begin : g_rx_entry
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    rx_mem_reg[gi] <= '0;
                else if (rx_write && (rx_wr_ptr_reg == RPW'(gi)))
                    rx_mem_reg[gi] <= link_data_i;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_wr_ptr_reg   <= '0;
            rx_rd_ptr_reg   <= '0;
            rx_count_reg    <= '0;
            link_credit_reg <= 1'b0;
            misroute_reg    <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            if (rx_write)
                rx_wr_ptr_reg <= (rx_wr_ptr_reg == RX_LAST) ? '0 : rx_wr_ptr_reg + 1'b1;
            if (rx_pop)
                rx_rd_ptr_reg <= (rx_rd_ptr_reg == RX_LAST) ? '0 : rx_rd_ptr_reg + 1'b1;
            case ({rx_write, rx_pop})
                2'b10:   rx_count_reg <= rx_count_reg + 1'b1;
                2'b01:   rx_count_reg <= rx_count_reg - 1'b1;
                default: rx_count_reg <= rx_count_reg;
            endcase
            link_credit_reg <= rx_pop;
            misroute_reg    <= link_enable_i && (link_data_i[7:0] != MY_ADDR);
            err_reg         <= err_reg || credit_err || rx_overflow;
        end
    end

    assign tx_ready_o     = !tx_full;
    assign link_data_o    = link_data_reg;
    assign link_enable_o  = link_enable_reg;
    assign link_credit_o  = link_credit_reg;
    assign rx_data_o      = rx_valid_o ? rx_mem_reg[rx_rd_ptr_reg] : '0;
    assign credit_count_o = credit_reg;
    assign misroute_o     = misroute_reg;
    assign err_o          = err_reg;
endmodule

// File: tb/tb_local_endpoint.sv
// Scoreboard bench for local_endpoint: TX flits are queued at push and matched at each
// link strobe; RX flits are queued at router write and matched as the core pops them.
module tb_local_endpoint;
    logic        clk, rst;
    logic        tx_valid_i;
    logic [7:0]  tx_dest_i, tx_payload_i;
    logic        tx_ready_o;
    logic [15:0] link_data_o;
    logic        link_enable_o, link_credit_i;
    logic [15:0] link_data_i;
    logic        link_enable_i, link_credit_o;
    logic        rx_valid_o;
    logic [15:0] rx_data_o;
    logic        rx_ready_i;
    logic [2:0]  credit_count_o;
    logic        misroute_o, err_o;

    local_endpoint #(.CREDITS(4), .TX_DEPTH(4), .XCOORD(0), .YCOORD(0)) dut (
        .clk(clk), .rst(rst),
        .tx_valid_i(tx_valid_i), .tx_dest_i(tx_dest_i), .tx_payload_i(tx_payload_i),
        .tx_ready_o(tx_ready_o),
        .link_data_o(link_data_o), .link_enable_o(link_enable_o), .link_credit_i(link_credit_i),
        .link_data_i(link_data_i), .link_enable_i(link_enable_i), .link_credit_o(link_credit_o),
        .rx_valid_o(rx_valid_o), .rx_data_o(rx_data_o), .rx_ready_i(rx_ready_i),
        .credit_count_o(credit_count_o), .misroute_o(misroute_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    int strobes = 0;
    int strobe_cyc[$];
    logic [15:0] tx_q[$];
    logic [15:0] rx_q[$];
    logic [15:0] mon_exp;

    always @(posedge clk) cycle <= cycle + 1;

    // TX scoreboard: every link strobe must carry the oldest accepted flit.
    always @(negedge clk) begin
        if (rst && link_enable_o) begin
            checks++;
            if (tx_q.size() == 0) begin
                errors++;
                $display("FAIL tx_strobe: got flit %h, want no strobe", link_data_o);
            end else begin
                mon_exp = tx_q.pop_front();
                if (link_data_o !== mon_exp) begin
                    errors++;
                    $display("FAIL tx_data: got %h want %h", link_data_o, mon_exp);
                end else
                    $display("tx flit %h cycle %0d", link_data_o, cycle);
            end
            strobes++;
            strobe_cyc.push_back(cycle);
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] dest, input logic [7:0] pl);
        int  n;
        bit  ok;
        tx_valid_i = 1'b1; tx_dest_i = dest; tx_payload_i = pl;
        n = 0;
        do begin
            ok = tx_ready_o;
            tick();
            n++;
        end while (!ok && n < 20);
        tx_valid_i = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL tx_push_timeout: got tx_ready_o=0 for %0d cycles want 1", n);
        end else begin
            tx_q.push_back({pl, dest});
            $display("push %h", {pl, dest});
        end
    endtask

    task automatic rx_write(input logic [15:0] d);
        link_enable_i = 1'b1; link_data_i = d;
        tick();
        link_enable_i = 1'b0;
        $display("rx write %h", d);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tx_q.delete(); rx_q.delete();
        tick(); tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        checks++; if (link_enable_o !== 1'b0) begin errors++; $display("FAIL reset_link_enable: got %b want 0", link_enable_o); end
        checks++; if (link_data_o !== 16'h0) begin errors++; $display("FAIL reset_link_data: got %h want 0000", link_data_o); end
        checks++; if (link_credit_o !== 1'b0) begin errors++; $display("FAIL reset_link_credit: got %b want 0", link_credit_o); end
        checks++; if (tx_ready_o !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready_o); end
        checks++; if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid_o); end
        checks++; if (rx_data_o !== 16'h0) begin errors++; $display("FAIL reset_rx_data: got %h want 0000", rx_data_o); end
        checks++; if (credit_count_o !== 3'd4) begin errors++; $display("FAIL reset_credits: got %0d want 4", credit_count_o); end
        checks++; if ({misroute_o, err_o} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {misroute_o, err_o}); end
        rst = 1'b1;
        tick();
        $display("reset done");
    endtask

    task automatic test_tx_burst();
        logic [7:0] pls [6];
        int s0;
        pls = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h01, 8'h02};
        s0 = strobes;
        for (int i = 0; i < 6; i++) push_tx(8'hA5, pls[i]);
        repeat (6) tick();
        checks++; if (strobes - s0 !== 4) begin errors++; $display("FAIL burst_strobes: got %0d want 4", strobes - s0); end
        checks++;
        if (strobes - s0 >= 4 && strobe_cyc[s0+3] - strobe_cyc[s0] !== 3) begin
            errors++; $display("FAIL burst_consecutive: got span %0d want 3", strobe_cyc[s0+3] - strobe_cyc[s0]);
        end
        checks++; if (credit_count_o !== 3'd0) begin errors++; $display("FAIL burst_credits: got %0d want 0", credit_count_o); end
        checks++; if (tx_q.size() !== 2) begin errors++; $display("FAIL burst_queued: got %0d want 2", tx_q.size()); end
        checks++; if (link_enable_o !== 1'b0) begin errors++; $display("FAIL burst_idle: got %b want 0", link_enable_o); end
    endtask

    task automatic test_credit_return();
        int s0;
        s0 = strobes;
        for (int i = 0; i < 2; i++) begin
            link_credit_i = 1'b1; tick(); link_credit_i = 1'b0;
            tick(); tick();
            $display("credit pulse %0d", i);
        end
        repeat (3) tick();
        checks++; if (strobes - s0 !== 2) begin errors++; $display("FAIL credit_strobes: got %0d want 2", strobes - s0); end
        checks++; if (tx_q.size() !== 0) begin errors++; $display("FAIL credit_drain: got %0d queued want 0", tx_q.size()); end
        checks++; if (credit_count_o !== 3'd0) begin errors++; $display("FAIL credit_after: got %0d want 0", credit_count_o); end
    endtask

    task automatic test_credit_simul();
        link_credit_i = 1'b1; tick(); tick(); link_credit_i = 1'b0;
        checks++; if (credit_count_o !== 3'd2) begin errors++; $display("FAIL simul_pre: got %0d want 2", credit_count_o); end
        push_tx(8'h3C, 8'h55);
        link_credit_i = 1'b1; tick(); link_credit_i = 1'b0;
        checks++; if (link_enable_o !== 1'b1) begin errors++; $display("FAIL simul_send: got %b want 1", link_enable_o); end
        checks++; if (credit_count_o !== 3'd2) begin errors++; $display("FAIL simul_credits: got %0d want 2", credit_count_o); end
        link_credit_i = 1'b1; tick(); tick(); link_credit_i = 1'b0;
        checks++; if ({err_o, credit_count_o} !== 4'b0_100) begin errors++; $display("FAIL simul_full: got err=%b cnt=%0d want err=0 cnt=4", err_o, credit_count_o); end
        link_credit_i = 1'b1; tick(); link_credit_i = 1'b0;
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL credit_overflow_err: got %b want 1", err_o); end
        checks++; if (credit_count_o !== 3'd4) begin errors++; $display("FAIL credit_overflow_cnt: got %0d want 4", credit_count_o); end
        $display("credit overflow seen");
    endtask

    task automatic test_rx_buffer();
        logic [15:0] e;
        do_reset();
        rx_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            e = {8'h40 + 8'(i), 8'h00};
            rx_q.push_back(e);
            rx_write(e);
            checks++; if (rx_valid_o !== 1'b1) begin errors++; $display("FAIL rx_valid_%0d: got %b want 1", i, rx_valid_o); end
            checks++; if ({misroute_o, link_credit_o} !== 2'b00) begin errors++; $display("FAIL rx_hold_%0d: got misroute/credit %b want 00", i, {misroute_o, link_credit_o}); end
        end
        tick();
        checks++; if (link_credit_o !== 1'b0) begin errors++; $display("FAIL rx_no_credit: got %b want 0", link_credit_o); end
        rx_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e = rx_q.pop_front();
            checks++; if (rx_valid_o !== 1'b1 || rx_data_o !== e) begin errors++; $display("FAIL rx_pop_%0d: got v=%b %h want v=1 %h", k, rx_valid_o, rx_data_o, e); end
            else $display("rx pop %h", rx_data_o);
            tick();
            checks++; if (link_credit_o !== 1'b1) begin errors++; $display("FAIL rx_credit_%0d: got %b want 1", k, link_credit_o); end
        end
        checks++; if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL rx_empty: got %b want 0", rx_valid_o); end
        tick();
        checks++; if (link_credit_o !== 1'b0) begin errors++; $display("FAIL rx_credit_end: got %b want 0", link_credit_o); end
        rx_ready_i = 1'b0;
    endtask

    task automatic test_rx_full();
        logic [15:0] e;
        for (int i = 0; i < 4; i++) begin
            e = {8'h60 + 8'(i), 8'h00};
            rx_q.push_back(e);
            rx_write(e);
        end
        e = rx_q.pop_front();
        checks++; if (rx_data_o !== e) begin errors++; $display("FAIL full_head: got %h want %h", rx_data_o, e); end
        rx_q.push_back(16'h7000);
        rx_ready_i = 1'b1;
        rx_write(16'h7000);
        rx_ready_i = 1'b0;
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL full_wr_pop_err: got %b want 0", err_o); end
        rx_write(16'h7100);
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL rx_overflow_err: got %b want 1", err_o); end
        rx_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e = rx_q.pop_front();
            checks++; if (rx_data_o !== e) begin errors++; $display("FAIL full_drain_%0d: got %h want %h", k, rx_data_o, e); end
            else $display("rx pop %h", rx_data_o);
            tick();
        end
        checks++; if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL full_dropped: got v=%b %h want v=0", rx_valid_o, rx_data_o); end
        rx_ready_i = 1'b0;
        rx_q.push_back(16'h9923);
        rx_write(16'h9923);
        checks++; if (misroute_o !== 1'b1) begin errors++; $display("FAIL misroute_pulse: got %b want 1", misroute_o); end
        tick();
        checks++; if (misroute_o !== 1'b0) begin errors++; $display("FAIL misroute_clear: got %b want 0", misroute_o); end
        e = rx_q.pop_front();
        checks++; if (rx_valid_o !== 1'b1 || rx_data_o !== e) begin errors++; $display("FAIL misroute_deliver: got v=%b %h want v=1 %h", rx_valid_o, rx_data_o, e); end
        rx_ready_i = 1'b1; tick(); rx_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        int s0;
        do_reset();
        link_credit_i = 1'b1; tick(); link_credit_i = 1'b0;
        for (int i = 0; i < 4; i++) push_tx(8'h11, 8'h20 + 8'(i));
        repeat (3) tick();
        for (int i = 0; i < 3; i++) push_tx(8'h11, 8'h30 + 8'(i));
        rx_write(16'hB000);
        rx_write(16'hB123);
        checks++; if ({err_o, misroute_o, rx_valid_o} !== 3'b111) begin errors++; $display("FAIL mid_pre: got err/mis/rxv %b want 111", {err_o, misroute_o, rx_valid_o}); end
        #1 rst = 1'b0;
        tx_q.delete(); rx_q.delete();
        #1;
        checks++; if ({link_enable_o, link_credit_o, misroute_o, err_o, rx_valid_o} !== 5'b0) begin errors++; $display("FAIL mid_flags: got %b want 00000", {link_enable_o, link_credit_o, misroute_o, err_o, rx_valid_o}); end
        checks++; if ({link_data_o, rx_data_o} !== 32'h0) begin errors++; $display("FAIL mid_data: got %h %h want 0000 0000", link_data_o, rx_data_o); end
        checks++; if ({tx_ready_o, credit_count_o} !== 4'b1_100) begin errors++; $display("FAIL mid_tx: got rdy=%b cnt=%0d want rdy=1 cnt=4", tx_ready_o, credit_count_o); end
        @(posedge clk); #3 rst = 1'b1;
        s0 = strobes;
        rx_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (link_credit_o !== 1'b0) begin errors++; $display("FAIL mid_credit_%0d: got %b want 0", i, link_credit_o); end
        end
        rx_ready_i = 1'b0;
        checks++; if (strobes !== s0) begin errors++; $display("FAIL mid_strobes: got %0d want 0", strobes - s0); end
        $display("mid-burst reset done");
    endtask

    initial begin
        rst = 1'b0;
        tx_valid_i = 1'b0; tx_dest_i = '0; tx_payload_i = '0;
        link_credit_i = 1'b0; link_data_i = '0; link_enable_i = 1'b0;
        rx_ready_i = 1'b0;
        test_reset();
        test_tx_burst();
        test_credit_return();
        test_credit_simul();
        test_rx_buffer();
        test_rx_full();
        test_reset_mid();
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/local_endpoint.md
# local_endpoint

Network-interface block that attaches a core to a router's local (L) port over the credit-based link. On the transmit side it accepts destination/payload pairs from the core, forms 16-bit flits, and injects them into the router under a credit counter. On the receive side it buffers flits ejected by the router, hands them to the core, and returns one credit per consumed flit. It is the far end of the router's local inputPort/outputPort pair.

## Interface
- CREDITS, 4: router local input buffer depth; initial credit count; also RX buffer depth.
- TX_DEPTH, 4: core-side TX FIFO depth (power of two, >=2).
- XCOORD, 0: this node's X coordinate (0-15).
- YCOORD, 0: this node's Y coordinate (0-15).

Ports:
- clk  in  1  the codebase's single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- tx_valid_i  in  1  core has a flit to send.
- tx_dest_i  in  8  destination {X[3:0],Y[3:0]}.
- tx_payload_i  in  8  payload byte.
- tx_ready_o  out  1  TX FIFO not full.
- link_data_o  out  16  flit to router, {payload,dest}; dest in [7:0].
- link_enable_o  out  1  one-cycle flit-valid strobe to router.
- link_credit_i  in  1  one-cycle credit-return pulse from router.
- link_data_i  in  16  flit from router.
- link_enable_i  in  1  flit-valid strobe from router.
- link_credit_o  out  1  one-cycle credit-return pulse to router.
- rx_valid_o  out  1  RX buffer not empty.
- rx_data_o  out  16  head of RX buffer (show-ahead).
- rx_ready_i  in  1  core consumes head when rx_valid_o high.
- credit_count_o  out  $clog2(CREDITS+1)  current TX credits.
- misroute_o  out  1  one-cycle pulse: received flit dest != {XCOORD,YCOORD}.
- err_o  out  1  sticky: credit overflow or RX overflow.

## Operation
- Reset (rst low, asynchronous): FIFOs empty, credits = CREDITS, link_enable_o=0, link_data_o=0, link_credit_o=0, misroute_o=0, err_o=0; tx_ready_o=1, rx_valid_o=0, rx_data_o=0. Reset mid-packet discards all buffered flits; no credits returned for discarded RX flits.
- TX push: on edge with tx_valid_i && tx_ready_o, write {tx_payload_i,tx_dest_i}.
- TX send: on edge with TX FIFO non-empty and credits>0: pop, register flit into link_data_o, link_enable_o=1 for that cycle; else link_enable_o=0, link_data_o holds last value.
- Credit counter: send only -> -1; link_credit_i only -> +1; both -> unchanged; never below 0. Increment at CREDITS (without a same-cycle send) -> hold at CREDITS, set err_o.
- RX write: every edge with link_enable_i, write link_data_i; compare [7:0] to {XCOORD[3:0],YCOORD[3:0]}, mismatch -> misroute_o=1 next cycle; flit still buffered.
- RX pop: rx_valid_o && rx_ready_i at edge -> pop; link_credit_o=1 the following cycle for exactly one cycle per pop.
- RX full with write and pop same edge: both occur, no overflow. Write while full without pop: flit dropped, err_o set.
- err_o clears only on reset.

## Timing
- TX latency: flit pushed at edge N into empty FIFO with credits>0 -> link_enable_o high in cycle after edge N+1. Empty-FIFO bypass not provided.
- Sustained TX: one flit per cycle while credits and data available.
- Credit arriving at edge N is usable for a send decision at edge N+1.
- RX: flit written at edge N -> rx_valid_o high after edge N; core may pop at edge N+1.
- Pop at edge N -> link_credit_o high from edge N to N+1.
- tx_ready_o, rx_valid_o, rx_data_o derive from registered FIFO state only (no combinational path from tx_valid_i or link inputs).

## Test plan
- Reset then push 6 flits back-to-back, no credits returned -> exactly 4 link_enable_o strobes on consecutive cycles, credit_count_o 4->0, tx_ready_o low once FIFO holds 4 remaining... verify 2 queued, no further sends.
- Same state, pulse link_credit_i twice -> 2 more strobes, data in push order, e.g. 0x01A5,0x02A5.
- Simultaneous send and link_credit_i with credits=2 -> credit_count_o stays 2; link_credit_i with credits=4 and idle TX -> err_o=1, count stays 4.
- Router writes 4 flits (dest 0x00, XCOORD=YCOORD=0), rx_ready_i low -> rx_valid_o=1, no link_credit_o; raise rx_ready_i -> 4 data in order, 4 credit pulses each one cycle after its pop.
- RX full, write with pop same edge -> no err_o; write with no pop -> flit dropped, err_o=1. Flit dest 0x23 -> misroute_o one-cycle pulse, flit delivered.
- Assert rst mid-burst with 3 TX and 2 RX flits buffered -> all outputs at reset values immediately, credits=4, no link_credit_o after release.
